// File: rtl/mem_decipher.sv
// mem_decipher: receive-side inverse of the four-box Enigma-style substitution.
// Ciphertext bytes stream in on a valid/ready face, pass through a two-stage
// pipeline (S1 capture, S2 decipher), and leave as plaintext on a second
// valid/ready face. The box setting auto-steps per accepted letter.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   key_load, key_in[1:0]  load the starting box setting (IDLE only)
//   flush                  stop accepting, drain the pipeline, return to IDLE
//   in_valid, in_data[7:0], in_ready       ciphertext input handshake
//   out_valid, out_data[7:0], out_ready    plaintext output handshake
//   busy                   not IDLE, or any pipeline stage occupied
//   setting[1:0]           box select for the next accepted letter
//   char_count[15:0]       letters deciphered since key load (wraps)
module mem_decipher #(
    parameter int unsigned SHIFT0  = 3,
    parameter int unsigned SHIFT1  = 7,
    parameter int unsigned SHIFT2  = 11,
    parameter int unsigned SHIFT3  = 19,
    parameter int unsigned STEP_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [1:0]  key_in,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic [1:0]  setting,
    output logic [15:0] char_count
);

    localparam int unsigned ALPHA = 26;

    // Additive inverses of each box shift, so decipher is an add mod 26
    localparam logic [5:0] INV0 = 6'(ALPHA - SHIFT0);
    localparam logic [5:0] INV1 = 6'(ALPHA - SHIFT1);
    localparam logic [5:0] INV2 = 6'(ALPHA - SHIFT2);
    localparam logic [5:0] INV3 = 6'(ALPHA - SHIFT3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic        s1_valid;
    logic [7:0]  s1_data;
    logic [1:0]  s1_set;

    logic        s2_free;
    logic        s1_adv;
    logic        accept;

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

    // Inverse substitution; letter offset plus inverse shift stays below 64,
    // so one conditional subtract brings it back into 0..25
    function automatic logic [7:0] decipher(input logic [7:0] b, input logic [1:0] sel);
        logic [5:0] inv;
        logic [5:0] t;
        case (sel)
            2'd0:    inv = INV0;
            2'd1:    inv = INV1;
            2'd2:    inv = INV2;
            default: inv = INV3;
        endcase
        t = 6'(b - 8'h41) + inv;
        if (t >= 6'(ALPHA)) begin
            t = t - 6'(ALPHA);
        end
        return is_letter(b) ? (8'h41 + 8'(t)) : b;
    endfunction

    // S2 can take a new byte when empty or when its byte leaves this cycle
    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = (state == RUN) && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE) || s1_valid || out_valid;

    // Control FSM, key/setting/count bookkeeping and both pipeline stages
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            setting    <= 2'd0;
            char_count <= 16'd0;
            s1_valid   <= 1'b0;
            s1_data    <= 8'h00;
            s1_set     <= 2'd0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (key_load) begin
                        state      <= RUN;
                        setting    <= key_in;
                        char_count <= 16'd0;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !out_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // accept only happens in RUN, so this never collides with a key load
            if (accept && is_letter(in_data)) begin
                if (STEP_EN != 0) begin
                    setting <= setting + 2'd1;
                end
                char_count <= char_count + 16'd1;
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_set   <= setting;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                out_valid <= 1'b1;
                out_data  <= decipher(s1_data, s1_set);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
